// File: rtl/patch_reducer_mc.sv
// Multi-channel patch row reducer: each channel folds a configured number of row
// partial sums into one patch sum, with one held and one pending result per channel.
module patch_reducer_mc #(
    parameter int unsigned N_CH      = 4,
    parameter int unsigned MAX_PATCH = 16,
    parameter int unsigned LANES     = 2,
    parameter int unsigned FP_SIZE   = 32,
    parameter int unsigned SATURATE  = 0
) (
    input  logic                      reset,
    input  logic                      dram_clk,
    input  logic [N_CH-1:0]           init,
    output logic [N_CH-1:0]           init_rdy,
    input  logic [$clog2(MAX_PATCH+1)-1:0] cfg_patch_size,
    input  logic [N_CH*FP_SIZE-1:0]   partial_sum,
    input  logic [N_CH*$clog2(LANES+1)-1:0] partial_sum_cnt,
    output logic [N_CH-1:0]           sum_valid,
    input  logic [N_CH-1:0]           sum_ready,
    output logic [N_CH*FP_SIZE-1:0]   sum,
    output logic [N_CH-1:0]           sum_ovf,
    output logic [N_CH-1:0]           sum_overrun
);
    localparam int unsigned PW = $clog2(MAX_PATCH + 1);
    localparam int unsigned CW = $clog2(LANES + 1);

    typedef enum logic [1:0] {S_IDLE, S_ACC, S_DONE} state_t;

    // Out-of-range patch sizes fall back to the largest supported patch.
    logic [PW-1:0] cfg_eff;
    always_comb begin
        cfg_eff = cfg_patch_size;
        if (cfg_patch_size == '0 || cfg_patch_size > PW'(MAX_PATCH)) begin
            cfg_eff = PW'(MAX_PATCH);
        end
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        state_t             state;
        state_t             state_nxt;
        logic [FP_SIZE-1:0] acc;
        logic [PW:0]        n_row;
        logic [PW-1:0]      target;
        logic               ovf;
        logic               overrun;
        logic [FP_SIZE-1:0] sum_r;
        logic               valid_r;
        logic               sum_ovf_r;
        logic               sum_ovr_r;
        logic               rdy_r;

        logic [CW-1:0]      cnt_raw;
        logic [CW-1:0]      cnt_eff;
        logic [FP_SIZE:0]   add_full;
        logic [FP_SIZE-1:0] acc_nxt;
        logic [PW:0]        n_nxt;
        logic               ovf_nxt;
        logic               overrun_nxt;
        logic               done_c;
        logic               out_free;
        logic               start;
        logic               beat;
        logic               load_c;

        // Beat datapath and completion decode.
        always_comb begin
            cnt_raw     = partial_sum_cnt[i*CW +: CW];
            cnt_eff     = (cnt_raw > CW'(LANES)) ? CW'(LANES) : cnt_raw;
            add_full    = {1'b0, acc} + {1'b0, partial_sum[i*FP_SIZE +: FP_SIZE]};
            ovf_nxt     = ovf | add_full[FP_SIZE];
            acc_nxt     = add_full[FP_SIZE-1:0];
            if (SATURATE != 0 && add_full[FP_SIZE]) begin
                acc_nxt = '1;
            end
            n_nxt       = n_row + (PW+1)'(cnt_eff);
            done_c      = n_nxt >= {1'b0, target};
            overrun_nxt = overrun | (n_nxt > {1'b0, target});
            out_free    = !valid_r || sum_ready[i];
            start       = init[i] && (state != S_DONE);
            beat        = (state == S_ACC) && !init[i] && (cnt_eff != '0);
            load_c      = (beat && done_c && out_free) || ((state == S_DONE) && out_free);
        end

        always_comb begin
            state_nxt = state;
            case (state)
                S_IDLE: if (init[i]) state_nxt = S_ACC;
                S_ACC: begin
                    if (beat && done_c) state_nxt = out_free ? S_IDLE : S_DONE;
                end
                S_DONE: if (out_free) state_nxt = S_IDLE;
                default: state_nxt = S_IDLE;
            endcase
        end

        always_ff @(posedge dram_clk or posedge reset) begin
            if (reset) begin
                state     <= S_IDLE;
                acc       <= '0;
                n_row     <= '0;
                target    <= '0;
                ovf       <= 1'b0;
                overrun   <= 1'b0;
                sum_r     <= '0;
                valid_r   <= 1'b0;
                sum_ovf_r <= 1'b0;
                sum_ovr_r <= 1'b0;
                rdy_r     <= 1'b0;
            end else begin
                state <= state_nxt;
                rdy_r <= (state_nxt == S_IDLE);
                if (start) begin
                    acc     <= '0;
                    n_row   <= '0;
                    ovf     <= 1'b0;
                    overrun <= 1'b0;
                    target  <= cfg_eff;
                end else if (beat) begin
                    acc     <= acc_nxt;
                    n_row   <= n_nxt;
                    ovf     <= ovf_nxt;
                    overrun <= overrun_nxt;
                end
                // A pending DONE result has already been folded into acc/flags.
                if (load_c) begin
                    sum_r     <= (state == S_DONE) ? acc : acc_nxt;
                    sum_ovf_r <= (state == S_DONE) ? ovf : ovf_nxt;
                    sum_ovr_r <= (state == S_DONE) ? overrun : overrun_nxt;
                    valid_r   <= 1'b1;
                end else if (sum_ready[i]) begin
                    valid_r <= 1'b0;
                end
            end
        end

        assign sum[i*FP_SIZE +: FP_SIZE] = sum_r;
        assign sum_valid[i]              = valid_r;
        assign sum_ovf[i]                = sum_ovf_r;
        assign sum_overrun[i]            = sum_ovr_r;
        assign init_rdy[i]               = rdy_r;
    end
endmodule

// File: tb/tb_patch_reducer_mc.sv
// Self-checking bench for patch_reducer_mc: vector table, scoreboard of expected
// sums, and directed multi-cycle sequences.
module tb_patch_reducer_mc;
    logic         dram_clk;
    logic         reset;
    logic [3:0]   init;
    logic [3:0]   init_rdy;
    logic [4:0]   cfg;
    logic [127:0] ps;
    logic [7:0]   pcnt;
    logic [3:0]   sum_valid;
    logic [3:0]   sum_ready;
    logic [127:0] sum;
    logic [3:0]   sum_ovf;
    logic [3:0]   sum_overrun;

    logic [0:0] init8, w_rdy, s_rdy, w_valid, s_valid, w_ovf, s_ovf, w_ovr, s_ovr, ready8;
    logic [7:0] ps8, w_sum, s_sum;
    logic [1:0] cnt8;

    patch_reducer_mc u_dut (
        .reset(reset), .dram_clk(dram_clk), .init(init), .init_rdy(init_rdy),
        .cfg_patch_size(cfg), .partial_sum(ps), .partial_sum_cnt(pcnt),
        .sum_valid(sum_valid), .sum_ready(sum_ready), .sum(sum),
        .sum_ovf(sum_ovf), .sum_overrun(sum_overrun)
    );

    patch_reducer_mc #(.N_CH(1), .FP_SIZE(8), .SATURATE(0)) u_wrap (
        .reset(reset), .dram_clk(dram_clk), .init(init8), .init_rdy(w_rdy),
        .cfg_patch_size(cfg), .partial_sum(ps8), .partial_sum_cnt(cnt8),
        .sum_valid(w_valid), .sum_ready(ready8), .sum(w_sum),
        .sum_ovf(w_ovf), .sum_overrun(w_ovr)
    );

    patch_reducer_mc #(.N_CH(1), .FP_SIZE(8), .SATURATE(1)) u_sat (
        .reset(reset), .dram_clk(dram_clk), .init(init8), .init_rdy(s_rdy),
        .cfg_patch_size(cfg), .partial_sum(ps8), .partial_sum_cnt(cnt8),
        .sum_valid(s_valid), .sum_ready(ready8), .sum(s_sum),
        .sum_ovf(s_ovf), .sum_overrun(s_ovr)
    );

    initial dram_clk = 1'b0;
    always #5 dram_clk = ~dram_clk;

    typedef struct {
        logic [31:0] s;
        logic        ovf;
        logic        ovr;
    } exp_t;

    typedef struct {
        int          ch;
        int          cfgv;
        logic [31:0] val;
        int          cnt;
        int          nb;
        logic [31:0] es;
        logic        eovf;
        logic        eovr;
    } vec_t;

    exp_t exp_q[4][$];
    vec_t tbl[6];
    int   nvec = 0;
    int   nerr = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        nvec++;
        if (act !== req) begin
            nerr++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic push(input int ch, input logic [31:0] s, input logic o, input logic r);
        exp_t e;
        e.s = s; e.ovf = o; e.ovr = r;
        exp_q[ch].push_back(e);
    endtask

    // One clock: scoreboard transfers at the falling edge, then step past the rising edge.
    task automatic tick();
        exp_t e;
        @(negedge dram_clk);
        if (!reset) begin
            for (int c = 0; c < 4; c++) begin
                if (sum_valid[c] && sum_ready[c]) begin
                    if (exp_q[c].size() == 0) begin
                        nvec++;
                        nerr++;
                        $display("FAIL unexpected_sum ch%0d: got %0h, none required", c, sum[c*32 +: 32]);
                    end else begin
                        e = exp_q[c].pop_front();
                        chk($sformatf("sum_ch%0d", c),
                            {30'd0, sum_ovf[c], sum_overrun[c], sum[c*32 +: 32]},
                            {30'd0, e.ovf, e.ovr, e.s});
                    end
                end
            end
        end
        @(posedge dram_clk);
        #1;
    endtask

    task automatic do_init(input int ch, input int cfgv);
        init[ch] = 1'b1;
        cfg      = 5'(cfgv);
        tick();
        init[ch] = 1'b0;
    endtask

    task automatic beat(input int ch, input int cnt, input logic [31:0] val);
        ps[ch*32 +: 32] = val;
        pcnt[ch*2 +: 2] = 2'(cnt);
        tick();
        pcnt[ch*2 +: 2] = 2'b0;
    endtask

    task automatic drain();
        int cyc = 0;
        while ((exp_q[0].size() + exp_q[1].size() + exp_q[2].size() + exp_q[3].size()) != 0
               && cyc < 50) begin
            tick();
            cyc++;
        end
        chk("drain_pending", 64'(exp_q[0].size() + exp_q[1].size() + exp_q[2].size() + exp_q[3].size()), 64'd0);
    endtask

    int          tgt[4];
    int          nrow[4];
    logic [31:0] macc[4];
    logic        movf[4];
    logic        movr[4];
    logic        act[4];

    initial begin
        logic [32:0] full;
        int          cnt, ce, it;
        logic [31:0] val;

        reset = 1'b1; init = '0; cfg = '0; ps = '0; pcnt = '0; sum_ready = 4'hF;
        init8 = '0; ps8 = '0; cnt8 = '0; ready8 = 1'b1;

        tbl[0] = '{0, 6,  32'd10,         1, 6, 32'd60,         1'b0, 1'b0};
        tbl[1] = '{1, 1,  32'd5,          2, 1, 32'd5,          1'b0, 1'b1};
        tbl[2] = '{2, 0,  32'd3,          2, 8, 32'd24,         1'b0, 1'b0};
        tbl[3] = '{3, 20, 32'd1,          3, 8, 32'd8,          1'b0, 1'b0};
        tbl[4] = '{0, 3,  32'hFFFF_FFFF,  1, 3, 32'hFFFF_FFFD,  1'b1, 1'b0};
        tbl[5] = '{1, 5,  32'd7,          2, 3, 32'd21,         1'b0, 1'b1};

        // Reset state.
        repeat (3) @(posedge dram_clk);
        #1;
        chk("rst_valid", 64'(sum_valid), 64'd0);
        chk("rst_init_rdy", 64'(init_rdy), 64'd0);
        reset = 1'b0;
        tick();
        chk("init_rdy_after_release", 64'({init_rdy, w_rdy, s_rdy}), 64'h3F);

        // Vector table: one patch per record with constant beats.
        for (int r = 0; r < 6; r++) begin
            do_init(tbl[r].ch, tbl[r].cfgv);
            for (int k = 0; k < tbl[r].nb; k++) begin
                if (k == tbl[r].nb - 1) push(tbl[r].ch, tbl[r].es, tbl[r].eovf, tbl[r].eovr);
                beat(tbl[r].ch, tbl[r].cnt, tbl[r].val);
                if (r == 0 && k == tbl[r].nb - 1)
                    chk("valid_after_last_beat", 64'(sum_valid[0]), 64'd1);
            end
        end
        drain();

        // Overrun on 3rd beat, with an ignored cnt=0 beat in between.
        do_init(2, 5);
        beat(2, 2, 32'd1);
        beat(2, 0, 32'd100);
        beat(2, 2, 32'd2);
        push(2, 32'd6, 1'b0, 1'b1);
        beat(2, 2, 32'd3);
        drain();

        // 8-bit wrap and saturate.
        init8 = 1'b1; cfg = 5'd2; tick(); init8 = 1'b0;
        ps8 = 8'd200; cnt8 = 2'd1; tick();
        ps8 = 8'd100; tick();
        cnt8 = 2'd0;
        chk("wrap8_sum", 64'({w_valid, w_ovf, w_ovr, w_sum}), {53'd0, 3'b110, 8'd44});
        chk("sat8_sum",  64'({s_valid, s_ovf, s_ovr, s_sum}), {53'd0, 3'b110, 8'd255});
        tick();
        chk("fp8_idle", 64'({w_rdy, s_rdy, w_valid, s_valid}), 64'b1100);

        // Held result plus pending result under backpressure.
        sum_ready[0] = 1'b0;
        do_init(0, 1);
        push(0, 32'd7, 1'b0, 1'b0);
        beat(0, 1, 32'd7);
        chk("a_loaded_rdy", 64'({init_rdy[0], sum_valid[0], sum[31:0]}), {30'd0, 2'b11, 32'd7});
        do_init(0, 1);
        push(0, 32'd9, 1'b0, 1'b0);
        beat(0, 1, 32'd9);
        chk("done_hold", 64'({init_rdy[0], sum_valid[0], sum[31:0]}), {30'd0, 2'b01, 32'd7});
        do_init(0, 3);
        beat(0, 1, 32'd55);
        chk("done_ignores", 64'({init_rdy[0], sum_valid[0], sum[31:0]}), {30'd0, 2'b01, 32'd7});
        sum_ready[0] = 1'b1;
        tick();
        chk("b_no_gap", 64'({init_rdy[0], sum_valid[0], sum[31:0]}), {30'd0, 2'b11, 32'd9});
        tick();
        chk("valid_drop", 64'(sum_valid[0]), 64'd0);
        drain();

        // Four channels, random interleaved beats, abort on ch2.
        tgt[0] = 1; tgt[1] = 3; tgt[2] = 6; tgt[3] = 16;
        for (int c = 0; c < 4; c++) begin
            do_init(c, tgt[c]);
            nrow[c] = 0; macc[c] = '0; movf[c] = 1'b0; movr[c] = 1'b0; act[c] = 1'b1;
        end
        it = 0;
        while ((act[0] | act[1] | act[2] | act[3]) && it < 300) begin
            for (int c = 0; c < 4; c++) begin
                cnt = act[c] ? int'($urandom_range(0, 3)) : 0;
                val = $urandom;
                if (it == 2 && c == 2) cnt = 3;
                ps[c*32 +: 32] = val;
                pcnt[c*2 +: 2] = 2'(cnt);
                ce = (cnt > 2) ? 2 : cnt;
                if (it == 2 && c == 2) begin
                    nrow[2] = 0; macc[2] = '0; movf[2] = 1'b0; movr[2] = 1'b0; tgt[2] = 6;
                end else if (act[c] && ce != 0) begin
                    full    = {1'b0, macc[c]} + {1'b0, val};
                    macc[c] = full[31:0];
                    movf[c] = movf[c] | full[32];
                    nrow[c] = nrow[c] + ce;
                    if (nrow[c] >= tgt[c]) begin
                        movr[c] = (nrow[c] > tgt[c]);
                        push(c, macc[c], movf[c], movr[c]);
                        act[c] = 1'b0;
                    end
                end
            end
            if (it == 2) begin
                init[2] = 1'b1;
                cfg     = 5'd6;
            end
            tick();
            init = '0;
            pcnt = '0;
            it++;
        end
        chk("multi_ch_timeout", 64'({act[0], act[1], act[2], act[3]}), 64'd0);
        drain();

        // Reset mid-patch while a result is held.
        sum_ready = 4'b1110;
        do_init(0, 1);
        beat(0, 1, 32'd4);
        do_init(1, 8);
        beat(1, 2, 32'd5);
        chk("pre_rst_held", 64'(sum_valid[0]), 64'd1);
        #2 reset = 1'b1;
        #1;
        chk("rst_async_valid", 64'({sum_valid, sum_ovf, sum_overrun, init_rdy}), 64'd0);
        for (int c = 0; c < 4; c++) chk($sformatf("rst_async_sum%0d", c), 64'(sum[c*32 +: 32]), 64'd0);
        tick();
        reset = 1'b0;
        sum_ready = 4'hF;
        for (int c = 0; c < 4; c++) exp_q[c].delete();
        beat(1, 2, 32'd5);
        beat(1, 2, 32'd5);
        tick();
        chk("post_rst_ignored", 64'({init_rdy, sum_valid}), 64'hF0);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
